// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ID->EX register, ALU/MUL, restoring divider, data_sram request, bypass view
module ex_stage #(
    parameter bit DIV_FAST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_valid,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  div_op,
    input  logic [4:0]  ld_ctrl,
    input  logic [2:0]  st_ctrl,
    input  logic [31:0] rkd_value,
    input  logic        rf_we,
    input  logic        res_from_mem,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] pc,
    input  logic        MEM_allow_in,
    output logic        EX_allow_in,
    output logic        EX_ready_go,
    output logic        EXreg_valid,
    output logic [31:0] EX_result,
    output logic [31:0] EX_rkd_value,
    output logic [4:0]  EX_ld_ctrl,
    output logic        EX_rf_we,
    output logic        EX_res_from_mem,
    output logic [4:0]  EX_rf_waddr,
    output logic [31:0] EX_pc,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [4:0]  EX_byp_waddr,
    output logic        EX_byp_we,
    output logic        EX_byp_is_load,
    output logic        EX_byp_ready,
    output logic [31:0] EX_byp_result
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t  div_state, div_state_nxt;

    logic        ex_valid;
    logic [31:0] src1_q, src2_q;
    logic [3:0]  alu_op_q;
    logic [2:0]  div_op_q;
    logic [2:0]  st_ctrl_q;

    logic [31:0] div_rem, div_quo, div_dvs, res_q, res_r;
    logic [4:0]  div_cnt;

    logic        is_div, is_signed, want_rem, div_zero;
    logic        src1_neg, src2_neg;
    logic [31:0] abs1, abs2;
    logic [32:0] div_tmp, div_diff;
    logic        div_fits;
    logic [31:0] quo_next, rem_next, quo_final, rem_final;
    logic        handoff;

    logic [63:0] mul_u;
    logic [31:0] mulh_s;
    logic [4:0]  shamt;
    logic [31:0] alu_result;

    assign is_div    = div_op_q[2];
    assign is_signed = div_op_q[1];
    assign want_rem  = div_op_q[0];
    assign div_zero  = (src2_q == 32'd0);

    assign src1_neg = is_signed & src1_q[31];
    assign src2_neg = is_signed & src2_q[31];
    assign abs1     = src1_neg ? -src1_q : src1_q;
    assign abs2     = src2_neg ? -src2_q : src2_q;

    // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
    assign div_tmp   = {div_rem, div_quo[31]};
    assign div_diff  = div_tmp - {1'b0, div_dvs};
    assign div_fits  = ~div_diff[32];
    assign quo_next  = {div_quo[30:0], div_fits};
    assign rem_next  = div_fits ? div_diff[31:0] : div_tmp[31:0];
    assign quo_final = (src1_neg ^ src2_neg) ? -quo_next : quo_next;
    assign rem_final = src1_neg ? -rem_next : rem_next;

    assign EX_ready_go = ex_valid & (~is_div | (div_state == DIV_DONE));
    assign handoff     = EX_ready_go & MEM_allow_in;
    assign EX_allow_in = ~ex_valid | handoff;
    assign EXreg_valid = ex_valid & EX_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid        <= 1'b0;
            src1_q          <= '0;
            src2_q          <= '0;
            alu_op_q        <= '0;
            div_op_q        <= '0;
            st_ctrl_q       <= '0;
            EX_rkd_value    <= '0;
            EX_ld_ctrl      <= '0;
            EX_rf_we        <= 1'b0;
            EX_res_from_mem <= 1'b0;
            EX_rf_waddr     <= '0;
            EX_pc           <= '0;
        end else if (ID_valid & EX_allow_in) begin
            ex_valid        <= 1'b1;
            src1_q          <= src1;
            src2_q          <= src2;
            alu_op_q        <= alu_op;
            div_op_q        <= div_op;
            st_ctrl_q       <= st_ctrl;
            EX_rkd_value    <= rkd_value;
            EX_ld_ctrl      <= ld_ctrl;
            EX_rf_we        <= rf_we;
            EX_res_from_mem <= res_from_mem;
            EX_rf_waddr     <= rf_waddr;
            EX_pc           <= pc;
        end else if (handoff) begin
            ex_valid        <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) div_state <= DIV_IDLE;
        else       div_state <= div_state_nxt;
    end

    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            DIV_IDLE: begin
                if (ex_valid & is_div)
                    div_state_nxt = (DIV_FAST_ZERO && div_zero) ? DIV_DONE : DIV_BUSY;
            end
            DIV_BUSY: begin
                if (div_cnt == 5'd31) div_state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                if (handoff) div_state_nxt = DIV_IDLE;
            end
            default: div_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_rem <= '0;
            div_quo <= '0;
            div_dvs <= '0;
            div_cnt <= '0;
            res_q   <= '0;
            res_r   <= '0;
        end else begin
            if (div_state == DIV_IDLE && div_state_nxt == DIV_BUSY) begin
                div_rem <= '0;
                div_quo <= abs1;
                div_dvs <= abs2;
                div_cnt <= '0;
            end else if (div_state == DIV_IDLE && div_state_nxt == DIV_DONE) begin
                res_q <= 32'hFFFF_FFFF;
                res_r <= src1_q;
            end else if (div_state == DIV_BUSY) begin
                div_rem <= rem_next;
                div_quo <= quo_next;
                div_cnt <= div_cnt + 5'd1;
                if (div_cnt == 5'd31) begin
                    // A zero divisor bypasses the sign fix so the remainder is the raw dividend.
                    res_q <= div_zero ? 32'hFFFF_FFFF : quo_final;
                    res_r <= div_zero ? src1_q : rem_final;
                end
            end
        end
    end

    // Signed high product from the unsigned one: subtract each operand where the other is negative.
    assign mul_u  = {32'd0, src1_q} * {32'd0, src2_q};
    assign mulh_s = mul_u[63:32] - (src1_q[31] ? src2_q : 32'd0) - (src2_q[31] ? src1_q : 32'd0);
    assign shamt  = src2_q[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_op_q)
            4'd0:  alu_result = src1_q + src2_q;
            4'd1:  alu_result = src1_q - src2_q;
            4'd2:  alu_result = {31'd0, $signed(src1_q) < $signed(src2_q)};
            4'd3:  alu_result = {31'd0, src1_q < src2_q};
            4'd4:  alu_result = src1_q & src2_q;
            4'd5:  alu_result = src1_q | src2_q;
            4'd6:  alu_result = ~(src1_q | src2_q);
            4'd7:  alu_result = src1_q ^ src2_q;
            4'd8:  alu_result = src1_q << shamt;
            4'd9:  alu_result = src1_q >> shamt;
            4'd10: alu_result = $signed(src1_q) >>> shamt;
            4'd11: alu_result = src2_q;
            4'd12: alu_result = mul_u[31:0];
            4'd13: alu_result = mulh_s;
            4'd14: alu_result = mul_u[63:32];
            default: alu_result = 32'd0;
        endcase
    end

    assign EX_result = is_div ? (want_rem ? res_r : res_q) : alu_result;

    assign data_sram_en   = handoff & ((|EX_ld_ctrl) | (|st_ctrl_q));
    assign data_sram_addr = EX_result;

    always_comb begin
        data_sram_we = 4'b0000;
        if (data_sram_en) begin
            if (st_ctrl_q[2])      data_sram_we = 4'b1111;
            else if (st_ctrl_q[1]) data_sram_we = EX_result[1] ? 4'b1100 : 4'b0011;
            else if (st_ctrl_q[0]) data_sram_we = 4'b0001 << EX_result[1:0];
        end
    end

    always_comb begin
        data_sram_wdata = EX_rkd_value;
        if (st_ctrl_q[0])      data_sram_wdata = {4{EX_rkd_value[7:0]}};
        else if (st_ctrl_q[1]) data_sram_wdata = {2{EX_rkd_value[15:0]}};
    end

    assign EX_byp_waddr   = EX_rf_waddr;
    assign EX_byp_we      = ex_valid & EX_rf_we;
    assign EX_byp_is_load = EX_res_from_mem;
    assign EX_byp_ready   = EX_ready_go;
    assign EX_byp_result  = EX_result;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_valid;
    logic [31:0] src1, src2;
    logic [3:0]  alu_op;
    logic [2:0]  div_op;
    logic [4:0]  ld_ctrl;
    logic [2:0]  st_ctrl;
    logic [31:0] rkd_value;
    logic        rf_we, res_from_mem;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic        MEM_allow_in;
    logic        EX_allow_in, EX_ready_go, EXreg_valid;
    logic [31:0] EX_result, EX_rkd_value, EX_pc;
    logic [4:0]  EX_ld_ctrl, EX_rf_waddr;
    logic        EX_rf_we, EX_res_from_mem;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [4:0]  EX_byp_waddr;
    logic        EX_byp_we, EX_byp_is_load, EX_byp_ready;
    logic [31:0] EX_byp_result;

    int checks = 0;
    int errors = 0;

    ex_stage #(.DIV_FAST_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .src1(src1), .src2(src2),
        .alu_op(alu_op), .div_op(div_op), .ld_ctrl(ld_ctrl), .st_ctrl(st_ctrl),
        .rkd_value(rkd_value), .rf_we(rf_we), .res_from_mem(res_from_mem),
        .rf_waddr(rf_waddr), .pc(pc), .MEM_allow_in(MEM_allow_in),
        .EX_allow_in(EX_allow_in), .EX_ready_go(EX_ready_go), .EXreg_valid(EXreg_valid),
        .EX_result(EX_result), .EX_rkd_value(EX_rkd_value), .EX_ld_ctrl(EX_ld_ctrl),
        .EX_rf_we(EX_rf_we), .EX_res_from_mem(EX_res_from_mem), .EX_rf_waddr(EX_rf_waddr),
        .EX_pc(EX_pc), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .EX_byp_waddr(EX_byp_waddr), .EX_byp_we(EX_byp_we), .EX_byp_is_load(EX_byp_is_load),
        .EX_byp_ready(EX_byp_ready), .EX_byp_result(EX_byp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        int sh;
        sa = $signed(a); sb = $signed(b); sp = sa * sb;
        ua = a; ub = b; up = ua * ub;
        sh = int'(b & 32'd31);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return 32'(sa >>> sh);
            4'd11: return b;
            4'd12: return up[31:0];
            4'd13: return sp[63:32];
            4'd14: return up[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic rem);
        logic neg_a, neg_b;
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        neg_a = sgn && a[31];
        neg_b = sgn && b[31];
        ma = neg_a ? -a : a;
        mb = neg_b ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (neg_a != neg_b) q = -q;
        if (neg_a) r = -r;
        return rem ? r : q;
    endfunction

    task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] dop, input logic [4:0] ld, input logic [2:0] st,
                             input logic [31:0] rkd, input logic we, input logic rfm,
                             input logic [4:0] wa, input logic [31:0] pcv);
        alu_op = op; src1 = a; src2 = b; div_op = dop; ld_ctrl = ld; st_ctrl = st;
        rkd_value = rkd; rf_we = we; res_from_mem = rfm; rf_waddr = wa; pc = pcv;
    endtask

    task automatic issue();
        ID_valid = 1'b1;
        @(posedge clk); #1;
        ID_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (EX_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow_in got %b want 1", EX_allow_in); end
        checks++; if (EX_ready_go !== 1'b0) begin errors++; $display("FAIL reset_ready_go got %b want 0", EX_ready_go); end
        checks++; if (EX_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", EX_result); end
        checks++; if ({data_sram_en, data_sram_we, data_sram_wdata} !== 37'd0) begin
            errors++; $display("FAIL reset_sram got en=%b we=%b wdata=%h want 0", data_sram_en, data_sram_we, data_sram_wdata); end
        checks++; if ({EX_pc, EX_rf_waddr, EX_byp_we, EX_byp_is_load, EXreg_valid} !== 40'd0) begin
            errors++; $display("FAIL reset_fields got pc=%h waddr=%0d byp_we=%b want 0", EX_pc, EX_rf_waddr, EX_byp_we); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        MEM_allow_in = 1'b1;
        set_instr(4'd0, 32'd5, 32'd7, 3'b000, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'd3, 32'h1c00_0000);
        issue();
        checks++; if (EX_result !== 32'd12) begin errors++; $display("FAIL add_result got %h want 0000000c", EX_result); end
        checks++; if ({EX_ready_go, EX_allow_in, data_sram_en} !== 3'b110) begin
            errors++; $display("FAIL add_handshake got rg/ai/en=%b want 110", {EX_ready_go, EX_allow_in, data_sram_en}); end
        checks++; if (EX_byp_we !== 1'b1 || EX_byp_waddr !== 5'd3) begin
            errors++; $display("FAIL add_bypass got we=%b waddr=%0d want 1/3", EX_byp_we, EX_byp_waddr); end
        @(posedge clk); #1;
        checks++; if (EX_byp_we !== 1'b0) begin errors++; $display("FAIL add_drain got byp_we=%b want 0", EX_byp_we); end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b, exp;
        logic [3:0] op;
        MEM_allow_in = 1'b1;
        for (int i = 0; i < 48; i++) begin
            op = 4'(i % 16);
            a = $urandom; b = $urandom;
            if (i % 3 == 0) a[31] = 1'b1;
            set_instr(op, a, b, 3'b000, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'd1, 32'(i));
            issue();
            exp = alu_model(op, a, b);
            checks++; if (EX_result !== exp || EX_ready_go !== 1'b1) begin
                errors++; $display("FAIL alu_op%0d got %h rg=%b want %h rg=1 (a=%h b=%h)", op, EX_result, EX_ready_go, exp, a, b); end
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] dop,
                           input int exp_lat, input int stall);
        int cycles;
        logic [31:0] exp, held;
        exp = div_model(a, b, dop[1], dop[0]);
        MEM_allow_in = (stall == 0);
        set_instr(4'd0, a, b, dop, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'd9, 32'h100);
        issue();
        cycles = 0;
        checks++; if (EX_allow_in !== 1'b0 || EX_byp_ready !== 1'b0) begin
            errors++; $display("FAIL div_busy_allow got ai=%b ready=%b want 0/0", EX_allow_in, EX_byp_ready); end
        while (!EX_ready_go && cycles < 100) begin
            checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL div_busy_req got en=%b want 0", data_sram_en); end
            @(posedge clk); #1;
            cycles++;
        end
        checks++; if (cycles !== exp_lat) begin errors++; $display("FAIL div_latency got %0d want %0d", cycles, exp_lat); end
        checks++; if (EX_result !== exp) begin
            errors++; $display("FAIL div_result got %h want %h (a=%h b=%h op=%b)", EX_result, exp, a, b, dop); end
        held = EX_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++; if (EX_ready_go !== 1'b1 || EX_result !== held || EX_allow_in !== 1'b0) begin
                errors++; $display("FAIL div_stall got rg=%b res=%h ai=%b want 1/%h/0", EX_ready_go, EX_result, EX_allow_in, held); end
        end
        MEM_allow_in = 1'b1;
        #1;
        checks++; if (EX_allow_in !== 1'b1) begin errors++; $display("FAIL div_handoff got ai=%b want 1", EX_allow_in); end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        run_div(32'hFFFF_FFF9, 32'd2, 3'b110, 33, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 3'b111, 33, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 33, 0);
        run_div(32'd1000, 32'd7, 3'b101, 33, 3);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            if (b == 32'd0) b = 32'd3;
            if (i % 2 == 1) b = -b;
            run_div(a, b, {1'b1, 1'(i % 4 < 2), 1'(i % 2)}, 33, 0);
        end
    endtask

    task automatic test_div_zero();
        run_div(32'd9, 32'd0, 3'b100, 1, 0);
        run_div(32'd9, 32'd0, 3'b101, 1, 0);
        run_div(32'hFFFF_FF00, 32'd0, 3'b111, 1, 0);
    endtask

    task automatic test_store();
        logic [31:0] addr, rkd, exp_wd;
        logic [3:0] exp_we;
        logic [2:0] st;
        int size, off;
        MEM_allow_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin st = 3'b001; addr = 32'h1003; rkd = 32'h1234_5678; end
            else if (i == 1) begin st = 3'b010; addr = 32'h1002; rkd = 32'h1234_5678; end
            else begin st = 3'b001 << $urandom_range(0, 2); addr = $urandom; rkd = $urandom; end
            size = st[2] ? 4 : (st[1] ? 2 : 1);
            off = int'(addr[1:0]) & ~(size - 1);
            exp_we = 4'(((1 << size) - 1) << off);
            for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = rkd[8*(k % size) +: 8];
            set_instr(4'd0, addr & 32'hFFFF_FFF0, {28'd0, addr[3:0]}, 3'b000, 5'd0, st, rkd, 1'b0, 1'b0, 5'd0, 32'h200);
            issue();
            checks++; if (data_sram_en !== 1'b1 || data_sram_we !== exp_we || data_sram_wdata !== exp_wd || data_sram_addr !== addr) begin
                errors++; $display("FAIL store%0d got en=%b we=%b wd=%h ad=%h want 1/%b/%h/%h",
                                   i, data_sram_en, data_sram_we, data_sram_wdata, data_sram_addr, exp_we, exp_wd, addr); end
            @(posedge clk); #1;
            checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0000) begin
                errors++; $display("FAIL store_once got en=%b we=%b want 0/0000", data_sram_en, data_sram_we); end
        end
    endtask

    task automatic test_load_stall();
        MEM_allow_in = 1'b0;
        set_instr(4'd0, 32'h2000, 32'h10, 3'b000, 5'b10000, 3'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 32'h300);
        issue();
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_sram_en !== 1'b0 || EX_byp_is_load !== 1'b1 || EX_result !== 32'h2010 || EX_allow_in !== 1'b0) begin
                errors++; $display("FAIL load_stall%0d got en=%b ld=%b res=%h ai=%b want 0/1/00002010/0",
                                   i, data_sram_en, EX_byp_is_load, EX_result, EX_allow_in); end
            @(posedge clk); #1;
        end
        MEM_allow_in = 1'b1;
        #1;
        checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b0000 || EX_byp_is_load !== 1'b1 || EX_ld_ctrl !== 5'b10000) begin
            errors++; $display("FAIL load_issue got en=%b we=%b ld=%b ctrl=%b want 1/0000/1/10000",
                               data_sram_en, data_sram_we, EX_byp_is_load, EX_ld_ctrl); end
        @(posedge clk); #1;
        checks++; if (data_sram_en !== 1'b0 || EX_byp_we !== 1'b0) begin
            errors++; $display("FAIL load_once got en=%b byp_we=%b want 0/0", data_sram_en, EX_byp_we); end
    endtask

    task automatic test_reset_busy();
        MEM_allow_in = 1'b1;
        set_instr(4'd0, 32'd100, 32'd7, 3'b110, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'd4, 32'h400);
        issue();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (EX_ready_go !== 1'b0) begin errors++; $display("FAIL rstbusy_pre got rg=%b want 0", EX_ready_go); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (EX_allow_in !== 1'b1 || EX_ready_go !== 1'b0 || data_sram_en !== 1'b0 || EX_byp_we !== 1'b0) begin
            errors++; $display("FAIL rstbusy_post got ai=%b rg=%b en=%b bwe=%b want 1/0/0/0",
                               EX_allow_in, EX_ready_go, data_sram_en, EX_byp_we); end
        set_instr(4'd0, 32'd40, 32'd2, 3'b000, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'd5, 32'h404);
        issue();
        checks++; if (EX_result !== 32'd42 || EX_ready_go !== 1'b1) begin
            errors++; $display("FAIL rstbusy_add got %h rg=%b want 0000002a rg=1", EX_result, EX_ready_go); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, pcv;
        logic [3:0] op;
        MEM_allow_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 11));
            a = $urandom; b = $urandom; pcv = 32'h500 + 32'(4 * i);
            set_instr(op, a, b, 3'b000, 5'd0, 3'd0, 32'd0, 1'b1, 1'b0, 5'(i), pcv);
            ID_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (EX_result !== alu_model(op, a, b) || EX_pc !== pcv || EX_allow_in !== 1'b1) begin
                errors++; $display("FAIL b2b%0d got res=%h pc=%h ai=%b want %h/%h/1",
                                   i, EX_result, EX_pc, EX_allow_in, alu_model(op, a, b), pcv); end
        end
        ID_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        ID_valid = 1'b0;
        MEM_allow_in = 1'b1;
        set_instr(4'd0, 32'd0, 32'd0, 3'b000, 5'd0, 3'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_add();
        test_alu_random();
        test_div();
        test_div_zero();
        test_store();
        test_load_stall();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
